// File: rtl/updown_counter_mod_if.sv
// ----------------------------------------------------------------------------
// updown_counter_mod_if
//   Command/status bundle for updown_counter_mod.
//   The master side drives enable, direction, load and load_value.
//   The slave side (the counter) returns counter_out and wrap.
//
//   Protocol: there is no valid/ready handshake. Every rising clk edge
//   samples one command, with this priority:
//     load > enable > hold.
//   The slave always accepts the command; there is no back-pressure.
//   counter_out and wrap update on that same edge.
// ----------------------------------------------------------------------------
interface updown_counter_mod_if #(
  parameter int WIDTH = 8
);
  logic             enable;
  logic             direction;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] counter_out;
  logic             wrap;

  modport master (
    output enable, direction, load, load_value,
    input  counter_out, wrap
  );

  modport slave (
    input  enable, direction, load, load_value,
    output counter_out, wrap
  );
endinterface

// File: rtl/updown_counter_mod.sv
// ----------------------------------------------------------------------------
// updown_counter_mod
//   Parametrised up/down counter over the range 0..MAX_VAL.
//   Features:
//     - configurable STEP;
//     - synchronous parallel load, clamped to MAX_VAL;
//     - registered one-cycle wrap flag.
//
//   Optional feature macro: UPDOWN_COUNTER_SAT_EN
//     undefined : modular wrap-around at the range boundaries (default).
//     defined   : saturate at 0 / MAX_VAL. wrap pulses on every enabled cycle
//                 whose step was clamped, including when already at the limit.
//
//   Reset rst is asynchronous, active-low. Assertion clears both outputs at
//   once; counting resumes on the first clk edge after release.
//
//   This design has no FSM. The only state is the count and the wrap flag.
// ----------------------------------------------------------------------------
module updown_counter_mod #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] STEP    = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic                 clk,
  input  logic                 rst,
  updown_counter_mod_if.slave  bus
);

  // Boundary arithmetic is done one bit wider than the count. This keeps
  // MAX_VAL+1 and count+STEP from overflowing.
  localparam logic [WIDTH:0] MAX_EXT  = {1'b0, MAX_VAL};
  localparam logic [WIDTH:0] STEP_EXT = {1'b0, STEP};
`ifndef UPDOWN_COUNTER_SAT_EN
  localparam logic [WIDTH:0] MOD_EXT  = MAX_EXT + {{WIDTH{1'b0}}, 1'b1};
`endif

  logic [WIDTH-1:0] count_q;
  logic             wrap_q;
  logic [WIDTH-1:0] count_d;
  logic             wrap_d;
  logic [WIDTH:0]   count_ext;
  logic [WIDTH:0]   sum_ext;

  // Next count and wrap flag for the command sampled on this edge
  always_comb begin
    count_ext = {1'b0, count_q};
    sum_ext   = count_ext + STEP_EXT;
    count_d   = count_q;
    wrap_d    = 1'b0;

    if (bus.load) begin
      count_d = (bus.load_value > MAX_VAL) ? MAX_VAL : bus.load_value;
    end else if (bus.enable) begin
      if (bus.direction) begin
        // Counting up: is the STEP past MAX_VAL?
        if (sum_ext > MAX_EXT) begin
          wrap_d = 1'b1;
`ifdef UPDOWN_COUNTER_SAT_EN
          count_d = MAX_VAL;
`else
          count_d = WIDTH'(sum_ext - MOD_EXT);
`endif
        end else begin
          count_d = count_q + STEP;
        end
      end else begin
        // Counting down: would the STEP go below zero?
        if (count_ext < STEP_EXT) begin
          wrap_d = 1'b1;
`ifdef UPDOWN_COUNTER_SAT_EN
          count_d = '0;
`else
          count_d = WIDTH'(count_ext + MOD_EXT - STEP_EXT);
`endif
        end else begin
          count_d = count_q - STEP;
        end
      end
    end
  end

  // Count and wrap registers, cleared asynchronously by rst
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.counter_out = count_q;
  assign bus.wrap        = wrap_q;

endmodule
